// File: rtl/router_reg_param.sv
// Ingress register stage: header capture, byte steering to the FIFO write bus,
// hold queue for full-FIFO bytes, parity check. Length check built with ROUTER_REG_LEN_CHECK_EN.
module router_reg_param #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 2,
  parameter int NUM_PORTS  = 3,
  parameter int HOLD_DEPTH = 2
) (
  input  logic                              clock,
  input  logic                              resetn,
  input  logic                              pkt_valid,
  input  logic                              fifo_full,
  input  logic                              rst_int_reg,
  input  logic                              detect_add,
  input  logic                              lfd_state,
  input  logic                              ld_state,
  input  logic                              laf_state,
  input  logic                              full_state,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [DATA_WIDTH-1:0]             dout,
  output logic                              dout_valid,
  output logic                              parity_done,
  output logic                              low_pkt_valid,
  output logic                              err,
  output logic                              len_err,
  output logic                              hold_ovf,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]   hold_count
);

  localparam int PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int CNT_W = $clog2(HOLD_DEPTH + 1);
  localparam logic [PTR_W-1:0]   LAST_PTR  = PTR_W'(HOLD_DEPTH - 1);
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(HOLD_DEPTH);
  localparam logic [ADDR_BITS:0] PORT_LIM  = NUM_PORTS[ADDR_BITS:0];

  logic [DATA_WIDTH-1:0] header_reg;
  logic [DATA_WIDTH-1:0] int_parity;
  logic [DATA_WIDTH-1:0] pkt_parity;
  logic [DATA_WIDTH-1:0] hold_mem [HOLD_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;

  logic [ADDR_BITS:0] hdr_addr;
  logic hdr_ok, accept, q_empty, q_full;
  logic load_hdr, load_direct, load_swap, drain;
  logic pop, push_req, drop, push, payload, parity_byte;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    hdr_addr    = {1'b0, data_in[ADDR_BITS-1:0]};
    hdr_ok      = detect_add && pkt_valid && (hdr_addr < PORT_LIM);
    q_empty     = (hold_count == '0);
    q_full      = (hold_count == DEPTH_CNT);
    load_hdr    = !detect_add && lfd_state;
    accept      = !detect_add && !lfd_state && ld_state;
    load_direct = accept && !fifo_full && q_empty;
    load_swap   = accept && !fifo_full && !q_empty;
    drain       = !detect_add && !lfd_state && !ld_state && laf_state && !q_empty && !fifo_full;
    pop         = load_swap || drain;
    push_req    = load_swap || (accept && fifo_full);
    drop        = push_req && q_full && !pop;
    push        = push_req && !drop;
    payload     = accept && pkt_valid && !full_state && !drop;
    parity_byte = accept && !pkt_valid && !low_pkt_valid;
  end

  // Hold queue: a simultaneous push and pop on a full queue reuses the slot being read.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      hold_count <= '0;
      // NOTE: the queue storage is small and must read as zero after reset, so it is reset too.
      for (int i = 0; i < HOLD_DEPTH; i++) hold_mem[i] <= '0;
    end else if (detect_add) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      hold_count <= '0;
    end else begin
      if (push) begin
        hold_mem[wr_ptr] <= data_in;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   hold_count <= hold_count + 1'b1;
        2'b01:   hold_count <= hold_count - 1'b1;
        default: hold_count <= hold_count;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      header_reg  <= '0;
      int_parity  <= '0;
      pkt_parity  <= '0;
      dout        <= '0;
      dout_valid  <= 1'b0;
      parity_done <= 1'b0;
      err         <= 1'b0;
      hold_ovf    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (detect_add) begin
        if (hdr_ok) header_reg <= data_in;
        int_parity  <= '0;
        parity_done <= 1'b0;
        err         <= 1'b0;
        hold_ovf    <= 1'b0;
      end else begin
        if (parity_done) err <= (int_parity != pkt_parity);
        if (load_hdr) begin
          dout       <= header_reg;
          dout_valid <= 1'b1;
          int_parity <= int_parity ^ header_reg;
        end else if (load_direct) begin
          dout       <= data_in;
          dout_valid <= 1'b1;
        end else if (pop) begin
          dout       <= hold_mem[rd_ptr];
          dout_valid <= 1'b1;
        end
        if (payload) int_parity <= int_parity ^ data_in;
        if (drop) hold_ovf <= 1'b1;
        if (parity_byte) begin
          pkt_parity  <= data_in;
          parity_done <= 1'b1;
        end
      end
    end
  end

  // End-of-packet flag: clear wins over set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          low_pkt_valid <= 1'b0;
    else if (rst_int_reg) low_pkt_valid <= 1'b0;
    else if (parity_byte) low_pkt_valid <= 1'b1;
  end

`ifdef ROUTER_REG_LEN_CHECK_EN
  logic [DATA_WIDTH-ADDR_BITS-1:0] exp_len;
  logic [DATA_WIDTH-ADDR_BITS-1:0] pay_cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      exp_len <= '0;
      pay_cnt <= '0;
      len_err <= 1'b0;
    end else if (detect_add) begin
      if (hdr_ok) exp_len <= data_in[DATA_WIDTH-1:ADDR_BITS];
      pay_cnt <= '0;
      len_err <= 1'b0;
    end else begin
      if (parity_done) len_err <= (pay_cnt != exp_len);
      if (payload && (pay_cnt != '1)) pay_cnt <= pay_cnt + 1'b1;
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg_param.sv
// Self-checking bench for router_reg_param: directed packet scenarios, then
// random strobes checked cycle by cycle against a queue-based reference model.
module tb_router_reg_param;

`ifdef ROUTER_REG_LEN_CHECK_EN
  localparam bit LEN_EN = 1'b1;
`else
  localparam bit LEN_EN = 1'b0;
`endif
  localparam int HOLD = 2;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, rst_int_reg;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic [7:0] data_in;
  logic [7:0] dout;
  logic       dout_valid, parity_done, low_pkt_valid, err, len_err, hold_ovf;
  logic [1:0] hold_count;

  router_reg_param dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .fifo_full(fifo_full),
    .rst_int_reg(rst_int_reg), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .data_in(data_in), .dout(dout), .dout_valid(dout_valid), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .err(err), .len_err(len_err), .hold_ovf(hold_ovf),
    .hold_count(hold_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: packet bookkeeping with plain integers and a byte queue.
  logic [7:0] m_header, m_int_par, m_pkt_par, m_dout;
  int         m_exp_len, m_pay;
  bit         m_pdone, m_lpv, m_err, m_len_err, m_ovf, m_dv;
  logic [7:0] m_q[$];
  logic [7:0] got[$];

  task automatic model_reset();
    m_header = 0; m_int_par = 0; m_pkt_par = 0; m_dout = 0;
    m_exp_len = 0; m_pay = 0;
    m_pdone = 0; m_lpv = 0; m_err = 0; m_len_err = 0; m_ovf = 0; m_dv = 0;
    m_q.delete();
  endtask

  task automatic model_step();
    bit       dropped, set_lpv;
    logic [7:0] head;
    dropped = 0;
    set_lpv = 0;
    m_dv = 0;
    if (detect_add) begin
      if (pkt_valid && (data_in % 4) < 3) begin
        m_header  = data_in;
        m_exp_len = data_in / 4;
      end
      m_int_par = 0; m_pay = 0; m_pdone = 0; m_err = 0; m_len_err = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (m_pdone) begin
        m_err     = (m_int_par != m_pkt_par);
        m_len_err = (m_pay != m_exp_len);
      end
      if (lfd_state) begin
        m_dout = m_header; m_dv = 1; m_int_par ^= m_header;
      end else if (ld_state) begin
        if (!fifo_full) begin
          if (m_q.size() == 0) m_dout = data_in;
          else begin
            head = m_q.pop_front();
            m_dout = head;
            m_q.push_back(data_in);
          end
          m_dv = 1;
        end else if (m_q.size() < HOLD) m_q.push_back(data_in);
        else begin
          dropped = 1; m_ovf = 1;
        end
        if (pkt_valid && !full_state && !dropped) begin
          m_int_par ^= data_in;
          if (m_pay < 63) m_pay++;
        end
        if (!pkt_valid && !m_lpv) begin
          m_pkt_par = data_in; m_pdone = 1; set_lpv = 1;
        end
      end else if (laf_state && m_q.size() > 0 && !fifo_full) begin
        head = m_q.pop_front();
        m_dout = head; m_dv = 1;
      end
    end
    if (rst_int_reg) m_lpv = 0;
    else if (set_lpv) m_lpv = 1;
  endtask

  task automatic compare_all();
    check("dout", dout, m_dout);
    check("dout_valid", dout_valid, m_dv);
    check("parity_done", parity_done, m_pdone);
    check("low_pkt_valid", low_pkt_valid, m_lpv);
    check("err", err, m_err);
    check("len_err", len_err, LEN_EN ? m_len_err : 1'b0);
    check("hold_ovf", hold_ovf, m_ovf);
    check("hold_count", hold_count, m_q.size());
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    if (dout_valid) got.push_back(dout);
    compare_all();
  endtask

  task automatic cyc(input bit da, input bit lfd, input bit ld, input bit laf, input bit fs,
                     input bit pv, input bit ff, input bit rir, input logic [7:0] d);
    detect_add = da; lfd_state = lfd; ld_state = ld; laf_state = laf; full_state = fs;
    pkt_valid = pv; fifo_full = ff; rst_int_reg = rir; data_in = d;
    tick();
  endtask

  task automatic idle(input bit rir);
    cyc(0, 0, 0, 0, 0, 0, 0, rir, 8'h00);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_flags"}, {dout_valid, parity_done, low_pkt_valid, err, len_err, hold_ovf}, 0);
    check({tag, "_hold_count"}, hold_count, 0);
  endtask

  task automatic check_stream(input string tag, input int n, input logic [63:0] bytes);
    logic [63:0] b;
    b = bytes;
    check({tag, "_count"}, got.size(), n);
    for (int i = 0; i < n && i < got.size(); i++)
      check({tag, "_byte"}, got[i], (b >> (8 * (n - 1 - i))) & 64'hFF);
    got.delete();
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] par);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, hdr);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, b0);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, b1);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, b2);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, par);
  endtask

  initial begin
    resetn = 1'b0;
    {pkt_valid, fifo_full, rst_int_reg, detect_add, lfd_state, ld_state, laf_state, full_state} = '0;
    data_in = 8'h00;
    model_reset();
    #12;
    check_zero("reset");
    @(negedge clock);
    resetn = 1'b1;

    // Good packet
    got.delete();
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    idle(0);
    check_stream("s1_stream", 5, 64'h0D_11_22_33_0D);
    check("s1_parity_done", parity_done, 1);
    check("s1_err", err, 0);
    check("s1_len_err", len_err, 0);
    idle(1);

    // Bad parity: err one cycle after parity_done, held
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0C);
    check("s2_pdone", parity_done, 1);
    check("s2_err_early", err, 0);
    idle(0);
    check("s2_err", err, 1);
    idle(0);
    idle(1);
    check("s2_err_held", err, 1);

    // Length mismatch; detect_add clears err
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 8'h11);
    check("s3_err_cleared", err, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, 8'h11);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, 8'h22);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, 8'h33);
    cyc(0, 0, 1, 0, 0, 0, 0, 0, 8'h11);
    idle(0);
    check("s3_err", err, 0);
    check("s3_len_err", len_err, LEN_EN);
    idle(1);

    // Hold queue fill, drain, overflow drop
    got.delete();
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 8'h0D);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 1, 0, 0, 8'h11);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h22);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h33);
    check("s4_count_full", hold_count, 2);
    check("s4_dout_held", dout, 8'h11);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    check("s4_drain0", dout, 8'h22);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    check("s4_drain1", dout, 8'h33);
    check("s4_count_empty", hold_count, 0);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h44);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h55);
    check("s4_ovf_before", hold_ovf, 0);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h66);
    check("s4_ovf", hold_ovf, 1);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 0, 1, 0, 0, 8'h00);
    idle(0);
    check_stream("s4_stream", 6, 64'h0D_11_22_33_44_55);

    // Invalid header address
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h77);
    check("s5_count_pre", hold_count, 1);
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 8'h07);
    check("s5_dout", dout, 8'h55);
    check("s5_count", hold_count, 0);
    check("s5_ovf", hold_ovf, 0);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    check("s5_header_kept", dout, 8'h0D);
    idle(1);

    // Asynchronous reset mid-payload, then a clean packet
    cyc(1, 0, 0, 0, 0, 1, 0, 0, 8'h0D);
    cyc(0, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 1, 1, 0, 8'h11);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check_zero("s6_async");
    @(negedge clock);
    resetn = 1'b1;
    got.delete();
    send_pkt(8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D);
    idle(0);
    check_stream("s6_stream", 5, 64'h0D_11_22_33_0D);
    check("s6_err", err, 0);
    check("s6_len_err", len_err, 0);

    // Random strobes against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, 8'($urandom));
      got.delete();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/router_reg_param.md
Name: router_reg_param

Overview:
Parametrised datapath register stage for the router's ingress side. It sits between the input pins and the per-port FIFOs, and is controlled by the router FSM state strobes.
- Latches the header and steers header and payload bytes to the FIFO write bus.
- Holds bytes that arrive while the target FIFO is full in a small multi-entry hold queue.
- Checks packet parity and, optionally, declared payload length against the received count.

Parameters:
DATA_WIDTH, 8, byte/bus width.
ADDR_BITS, 2, low header bits giving the destination port.
NUM_PORTS, 3, valid destination count; a header address >= NUM_PORTS is invalid.
HOLD_DEPTH, 2, hold-queue entries (>=1).

Ports:
clock  in  1  single clock, rising edge
resetn  in  1  asynchronous active-low reset
pkt_valid  in  1  packet byte valid; low marks the parity byte
fifo_full  in  1  target FIFO full
rst_int_reg  in  1  clears low_pkt_valid
detect_add, lfd_state, ld_state, laf_state, full_state  in  1 each  FSM state strobes
data_in  in  DATA_WIDTH  ingress byte
dout  out  DATA_WIDTH  FIFO write data
dout_valid  out  1  one-cycle pulse when dout is loaded
parity_done  out  1  parity byte captured
low_pkt_valid  out  1  end of packet seen
err  out  1  parity mismatch
len_err  out  1  length mismatch
hold_ovf  out  1  sticky; a hold-queue byte was dropped
hold_count  out  $clog2(HOLD_DEPTH+1)  occupied hold entries

Behaviour:
Reset:
- Asynchronous and active-low: all outputs and internal registers go to 0 immediately, including mid-packet.

Header capture:
- When detect_add && pkt_valid && data_in[ADDR_BITS-1:0] < NUM_PORTS: header_reg <= data_in and exp_len <= data_in[DATA_WIDTH-1:ADDR_BITS].
- Any detect_add also clears: int_parity, pay_cnt, parity_done, err, len_err, hold_ovf and the hold queue.
- detect_add has priority over every other strobe.

Accepted byte:
- A byte is accepted when ld_state=1; it is pushed to the hold queue if the path below requires it.

dout load priority (each load pulses dout_valid the same cycle dout updates):
1. lfd_state: dout <= header_reg; int_parity ^= header_reg.
2. ld_state && !fifo_full && queue empty: dout <= data_in.
3. ld_state && !fifo_full && queue non-empty: dout <= queue head, pop, push data_in. Order is preserved and count is unchanged.
4. ld_state && fifo_full: push data_in; dout holds; no pulse.
5. laf_state && queue non-empty && !fifo_full: dout <= head, pop.
6. Otherwise dout holds and dout_valid=0.

Hold queue:
- Circular, HOLD_DEPTH entries; read and write pointers wrap at HOLD_DEPTH.
- A push when full with no pop in the same cycle drops data_in and sets hold_ovf.
- Push and pop in the same cycle is always legal.

Parity and length tracking:
- Payload byte = accepted with pkt_valid=1 and full_state=0, and not dropped.
- For each payload byte: int_parity ^= data_in, and pay_cnt increments, saturating at all-ones.
- Parity byte = first accepted byte with pkt_valid=0 while low_pkt_valid=0.
  - pkt_parity <= data_in.
  - parity_done <= 1 next edge.
  - low_pkt_valid <= 1.
  - The parity byte still goes to dout or the queue like a data byte.

Result checks:
- While parity_done=1: err <= (int_parity != pkt_parity) and len_err <= (pay_cnt != exp_len).
- Both are valid 1 cycle after parity_done rises and hold until the next detect_add.

low_pkt_valid:
- rst_int_reg clears it, with priority over set.
- Otherwise it is sticky.

Optional Feature:
ROUTER_REG_LEN_CHECK_EN:
- Defined: pay_cnt, exp_len and the len_err logic exist as described above.
- Undefined: those registers are not built and len_err is tied to 0.
- All other behaviour is identical in both cases.

Test Plan:
All scenarios use defaults, with ROUTER_REG_LEN_CHECK_EN defined.
1. Good packet: header 8'h0D (len 3, addr 1), payload 11/22/33, parity 8'h0D. Response: dout sequence 0D,11,22,33,0D with 5 dout_valid pulses; parity_done=1; err=0; len_err=0.
2. Same packet with parity 8'h0C: err=1 one cycle after parity_done, held until next detect_add clears it.
3. Header 8'h11 (len 4), payload 11/22/33, parity 8'h11: err=0, len_err=1.
4. fifo_full=1 while 22 and 33 arrive: hold_count=2. Then laf_state with fifo_full=0 gives dout 22 then 33 and hold_count back to 0. A third push while full sets hold_ovf=1 and that byte never appears on dout.
5. detect_add with data_in 8'h07 (addr 3): header_reg keeps its previous value and dout does not change. Packet-state registers are still cleared (int_parity, pay_cnt, parity_done, err, len_err, hold_ovf, hold queue).
6. resetn=0 between clock edges mid-payload: all outputs 0 immediately. A following good packet behaves as in scenario 1.
